// File: rtl/led_scan_if.sv
// -----------------------------------------------------------------------------
// led_scan_if
// Bus between the ALU side and the LED scan controller.
//   led_in    : 8-bit segment pattern from the ALU (bit7=a .. bit1=g, bit0=dp)
//   out_valid : one-cycle strobe qualifying led_in (ALU OUT instruction)
//   hlt       : ALU halt output
//   clear     : synchronous buffer clear
//   seg_n     : active-low segment drive, same bit order as led_in
//   dig_n     : active-low digit select, bit 0 = rightmost digit
//   count     : number of valid buffer entries
//   halted    : sticky halt flag
// master = ALU / system side, slave = the scan controller.
// -----------------------------------------------------------------------------
interface led_scan_if #(
  parameter int DIGITS = 4
);
  logic [7:0]        led_in;
  logic              out_valid;
  logic              hlt;
  logic              clear;
  logic [7:0]        seg_n;
  logic [DIGITS-1:0] dig_n;
  logic [3:0]        count;
  logic              halted;

  modport master (
    output led_in, out_valid, hlt, clear,
    input  seg_n, dig_n, count, halted
  );

  modport slave (
    input  led_in, out_valid, hlt, clear,
    output seg_n, dig_n, count, halted
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_scan_ctrl
// Captures the seven-segment patterns the ALU emits on OUT into a DIGITS-deep
// shift buffer and time-multiplexes them onto a common-anode display. Every
// digit slot is SCAN_DIV cycles long and starts with one blank cycle so two
// digits are never driven at once. A halt from the ALU is latched and shown
// by forcing the decimal point of digit 0 on.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : led_scan_if slave modport (see interface for signal list)
// -----------------------------------------------------------------------------
module led_scan_ctrl #(
  parameter int DIGITS   = 4,     // 2..8
  parameter int SCAN_DIV = 1024   // cycles per digit slot, >= 2
) (
  input logic     clk,
  input logic     rst_n,
  led_scan_if.slave bus
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [3:0]       COUNT_MAX = 4'(DIGITS);

  logic [7:0]        digit_buf_q [DIGITS];
  logic [7:0]        digit_buf_d [DIGITS];
  logic [3:0]        count_q, count_d;
  logic              halted_q, halted_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        seg_n_q, seg_n_d;
  logic [DIGITS-1:0] dig_n_q, dig_n_d;

  // NOTE: every signal written here gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    digit_buf_d = digit_buf_q;
    count_d     = count_q;
    halted_d    = halted_q | bus.hlt;
    pre_d       = pre_q + 1'b1;
    idx_d       = idx_q;
    seg_n_d     = '1;
    dig_n_d     = '1;

    // Clear wins over a simultaneous write; halt freezes the buffer.
    if (bus.clear) begin
      for (int i = 0; i < DIGITS; i++) digit_buf_d[i] = '0;
      count_d = '0;
    end else if (bus.out_valid && !halted_q) begin
      digit_buf_d[0] = bus.led_in;
      for (int i = 1; i < DIGITS; i++) digit_buf_d[i] = digit_buf_q[i-1];
      count_d = (count_q == COUNT_MAX) ? count_q : count_q + 4'd1;
    end

    // Free-running scan, independent of writes, clear and halt.
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // pre == 0 is the dead-time slot: everything off between digits.
    if (pre_q != '0) begin
      dig_n_d = ~(DIGITS'(1) << idx_q);
      seg_n_d = ~(digit_buf_q[idx_q] |
                  ((halted_q && (idx_q == '0)) ? 8'h01 : 8'h00));
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer is a handful of flops, not a RAM, and an unwritten
      // digit must display blank, so it is reset like any other register.
      for (int i = 0; i < DIGITS; i++) digit_buf_q[i] <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_n_q  <= '1;
      dig_n_q  <= '1;
    end else begin
      digit_buf_q <= digit_buf_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      seg_n_q     <= seg_n_d;
      dig_n_q     <= dig_n_d;
    end
  end

  assign bus.seg_n  = seg_n_q;
  assign bus.dig_n  = dig_n_q;
  assign bus.count  = count_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_scan_ctrl
// Directed bench for led_scan_ctrl with DIGITS=4, SCAN_DIV=4. Expected digit
// contents are pushed to a scoreboard queue as stimulus is applied and popped
// when the scan reaches that digit on the display.
// -----------------------------------------------------------------------------
module tb_led_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk;
  logic rst_n;

  led_scan_if #(.DIGITS(DIGITS)) bus ();

  led_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         digit;
    logic [7:0] seg;
  } exp_t;

  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after a rising edge: outputs are stable, inputs safe to drive.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] v);
    bus.led_in    = v;
    bus.out_valid = 1'b1;
    tick();
    bus.out_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic expect_digit(input int d, input logic [7:0] s);
    exp_t e;
    e.digit = d;
    e.seg   = s;
    sb.push_back(e);
  endtask

  // Pop each expected digit when the display selects it; bounded to 3 frames.
  task automatic drain_sb();
    int budget = 3 * FRAME;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
      if (bus.dig_n == ~(DIGITS'(1) << sb[0].digit)) begin
        exp_t e = sb.pop_front();
        check($sformatf("%s_dig%0d_seg", phase, e.digit), 32'(bus.seg_n),
              32'(e.seg));
      end
    end
    if (sb.size() > 0) begin
      check($sformatf("%s_scan_timeout", phase), sb.size(), 0);
      sb.delete();
    end
  endtask

  // Check the blank/digit pattern for n edges after a reset release.
  task automatic check_scan_from_reset(input int n);
    for (int e = 1; e <= n; e++) begin
      int slot = ((e - 1) / SCAN_DIV) % DIGITS;
      int p    = (e - 1) % SCAN_DIV;
      logic [DIGITS-1:0] exp_dig;
      tick();
      exp_dig = (p == 0) ? '1 : ~(DIGITS'(1) << slot);
      check($sformatf("%s_edge%0d_dig_n", phase, e), 32'(bus.dig_n),
            32'(exp_dig));
      check($sformatf("%s_edge%0d_seg_n", phase, e), 32'(bus.seg_n), 32'hFF);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.led_in    = '0;
    bus.out_valid = 1'b0;
    bus.hlt       = 1'b0;
    bus.clear     = 1'b0;

    // 1. Reset values, then the scan pattern with an empty buffer.
    phase = "reset";
    repeat (2) tick();
    check("reset_seg_n",  32'(bus.seg_n),  32'hFF);
    check("reset_dig_n",  32'(bus.dig_n),  32'hF);
    check("reset_count",  32'(bus.count),  32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    rst_n = 1'b1;
    phase = "scan";
    check_scan_from_reset(FRAME);
    check("scan_count", 32'(bus.count), 32'd0);

    // 2. Load three patterns.
    phase = "load";
    write(8'hFC);
    write(8'h60);
    write(8'hDA);
    check("load_count", 32'(bus.count), 32'd3);
    expect_digit(0, 8'h25);
    expect_digit(1, 8'h9F);
    expect_digit(2, 8'h03);
    expect_digit(3, 8'hFF);
    drain_sb();

    // 3. Overflow: count saturates, oldest patterns fall off.
    phase = "ovf";
    for (int k = 1; k <= 6; k++) begin
      write(8'(k));
      check($sformatf("ovf_count_w%0d", k), 32'(bus.count),
            (3 + k > DIGITS) ? DIGITS : 3 + k);
    end
    expect_digit(0, 8'hF9);
    expect_digit(1, 8'hFA);
    expect_digit(2, 8'hFB);
    expect_digit(3, 8'hFC);
    drain_sb();

    // 4. Clear colliding with a write: clear wins.
    phase = "clr";
    pulse_clear();
    check("clr_count_plain", 32'(bus.count), 32'd0);
    write(8'h11);
    write(8'h22);
    check("clr_count_pre", 32'(bus.count), 32'd2);
    bus.clear     = 1'b1;
    bus.out_valid = 1'b1;
    bus.led_in    = 8'hEE;
    tick();
    bus.clear     = 1'b0;
    bus.out_valid = 1'b0;
    check("clr_count_post", 32'(bus.count), 32'd0);
    for (int d = 0; d < DIGITS; d++) expect_digit(d, 8'hFF);
    drain_sb();

    // 5. Asynchronous reset in the middle of the digit 2 slot.
    phase = "arst";
    write(8'h81);
    write(8'h42);
    write(8'h24);
    bus.hlt = 1'b1;
    tick();
    bus.hlt = 1'b0;
    check("arst_pre_count",  32'(bus.count),  32'd3);
    check("arst_pre_halted", 32'(bus.halted), 32'd1);
    begin
      int budget = 2 * FRAME;
      while (bus.dig_n != 4'b1011 && budget > 0) begin
        tick();
        budget--;
      end
    end
    check("arst_pre_dig_n", 32'(bus.dig_n), 32'hB);
    check("arst_pre_seg_n", 32'(bus.seg_n), 32'h7E);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg_n",  32'(bus.seg_n),  32'hFF);
    check("arst_dig_n",  32'(bus.dig_n),  32'hF);
    check("arst_count",  32'(bus.count),  32'd0);
    check("arst_halted", 32'(bus.halted), 32'd0);
    tick();
    rst_n = 1'b1;
    check_scan_from_reset(SCAN_DIV + 1);
    expect_digit(2, 8'hFF);
    drain_sb();

    // 6. Halt: dp forced on digit 0, writes ignored, clear keeps halt.
    phase = "hlt";
    write(8'hB6);
    check("hlt_count_pre", 32'(bus.count), 32'd1);
    bus.hlt = 1'b1;
    tick();
    bus.hlt = 1'b0;
    check("hlt_halted_set", 32'(bus.halted), 32'd1);
    expect_digit(0, 8'h48);
    expect_digit(1, 8'hFF);
    drain_sb();
    check("hlt_halted_sticky", 32'(bus.halted), 32'd1);
    write(8'h60);
    check("hlt_count_ignored", 32'(bus.count), 32'd1);
    expect_digit(0, 8'h48);
    expect_digit(1, 8'hFF);
    drain_sb();
    pulse_clear();
    check("hlt_clear_count",  32'(bus.count),  32'd0);
    check("hlt_clear_halted", 32'(bus.halted), 32'd1);
    phase = "hlt_clr";
    expect_digit(0, 8'hFE);
    expect_digit(1, 8'hFF);
    drain_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
